// File: rtl/concat_pkg.sv
// concat_pkg: shared types and default widths for the header/nonce
// concatenator.
//   estado_t     IDLE / RUN / DONE state encoding
//   HDR_W_DEF    default header width
//   NONCE_W_DEF  default nonce width
package concat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } estado_t;

    localparam int HDR_W_DEF   = 96;
    localparam int NONCE_W_DEF = 32;

endpackage

// File: rtl/contador_nonce.sv
// contador_nonce: loadable nonce counter with an inclusive upper limit.
//   clk, reset_L  clock, async active-low reset
//   load          latch valor_ini into the counter and limite into the limit register
//   en            advance the counter by one (wraps modulo 2^NONCE_W)
//   valor_ini     starting nonce
//   limite        last nonce, inclusive
//   nonce_q       current nonce
//   last          nonce_q equals the latched limit
module contador_nonce #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               load,
    input  logic               en,
    input  logic [NONCE_W-1:0] valor_ini,
    input  logic [NONCE_W-1:0] limite,
    output logic [NONCE_W-1:0] nonce_q,
    output logic               last
);

    logic [NONCE_W-1:0] fin_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            nonce_q <= '0;
            fin_q   <= '0;
        end else if (load) begin
            nonce_q <= valor_ini;
            fin_q   <= limite;
        end else if (en) begin
            // Natural overflow gives the wrap 2^NONCE_W-1 -> 0.
            nonce_q <= nonce_q + NONCE_W'(1);
        end
    end

    assign last = (nonce_q == fin_q);

endmodule

// File: rtl/concatenador_barrido.sv
// concatenador_barrido: latches a block header, then sweeps the nonce range
// [nonce_ini .. nonce_fin] (inclusive, wrapping), emitting one {header, nonce}
// block per valid/ready transfer to the hash core.
//   clk, reset_L  clock, async active-low reset
//   start         begin a sweep (only honoured in IDLE)
//   entrada       header, latched with start
//   nonce_ini     first nonce, latched with start
//   nonce_fin     last nonce (inclusive), latched with start
//   ready_in      hash core accepts the current block
//   stop          (only with CONCAT_STOP_EN) abort the sweep after this cycle
//   bloque_in     {header_q, nonce_q}, header in MSBs
//   valid_out     bloque_in holds a valid block
//   busy          sweep in progress
//   done          one-cycle pulse after the sweep ends
// Optional feature macro: CONCAT_STOP_EN adds the stop input.
module concatenador_barrido
    import concat_pkg::*;
#(
    parameter int HDR_W   = HDR_W_DEF,
    parameter int NONCE_W = NONCE_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       start,
    input  logic [HDR_W-1:0]           entrada,
    input  logic [NONCE_W-1:0]         nonce_ini,
    input  logic [NONCE_W-1:0]         nonce_fin,
    input  logic                       ready_in,
`ifdef CONCAT_STOP_EN
    input  logic                       stop,
`endif
    output logic [HDR_W+NONCE_W-1:0]   bloque_in,
    output logic                       valid_out,
    output logic                       busy,
    output logic                       done
);

    estado_t            estado, estado_sig;
    logic [HDR_W-1:0]   header_q;
    logic [NONCE_W-1:0] nonce_q;
    logic               last;
    logic               carga, acepta, avanza, stop_w;

`ifdef CONCAT_STOP_EN
    assign stop_w = stop && (estado == RUN);
`else
    assign stop_w = 1'b0;
`endif

    assign carga  = (estado == IDLE) && start;
    assign acepta = (estado == RUN) && ready_in;
    // The final block and a stopped sweep leave the nonce where it is, so
    // bloque_in keeps showing the last block offered.
    assign avanza = acepta && !last && !stop_w;

    contador_nonce #(.NONCE_W(NONCE_W)) u_contador (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (carga),
        .en        (avanza),
        .valor_ini (nonce_ini),
        .limite    (nonce_fin),
        .nonce_q   (nonce_q),
        .last      (last)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            estado   <= IDLE;
            header_q <= '0;
        end else begin
            estado <= estado_sig;
            if (carga) header_q <= entrada;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (start) estado_sig = RUN;
            RUN:     if (stop_w || (acepta && last)) estado_sig = DONE;
            DONE:    estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // All outputs decode straight from flops: no combinational path from
    // inputs, and valid_out can only fall through a RUN->DONE transition.
    assign bloque_in = {header_q, nonce_q};
    assign valid_out = (estado == RUN);
    assign busy      = (estado == RUN);
    assign done      = (estado == DONE);

endmodule

// File: tb/tb_concatenador_barrido.sv
// tb_concatenador_barrido: directed and randomized sweeps checked against a
// reference model that predicts the k-th accepted block as
// {header, ini + k} and the block count as ((fin - ini) mod 2^32) + 1.
module tb_concatenador_barrido;

    logic         clk = 1'b0;
    logic         reset_L = 1'b0;
    logic         start = 1'b0;
    logic         ready_in = 1'b0;
    logic [95:0]  entrada = '0;
    logic [31:0]  nonce_ini = '0;
    logic [31:0]  nonce_fin = '0;
    logic [127:0] bloque_in;
    logic         valid_out, busy, done;
`ifdef CONCAT_STOP_EN
    logic         stop = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    concatenador_barrido dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .start     (start),
        .entrada   (entrada),
        .nonce_ini (nonce_ini),
        .nonce_fin (nonce_fin),
        .ready_in  (ready_in),
`ifdef CONCAT_STOP_EN
        .stop      (stop),
`endif
        .bloque_in (bloque_in),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic b, input logic d);
        chk({tag, "_valid"}, 128'(valid_out), 128'(v));
        chk({tag, "_busy"},  128'(busy),      128'(b));
        chk({tag, "_done"},  128'(done),      128'(d));
    endtask

    // One full sweep. Ready comes from pat (if plen>0) or random at pct%.
    // poke_start throws spurious start pulses during RUN and DONE.
    task automatic sweep(input logic [95:0] hdr, input logic [31:0] ini, input logic [31:0] fin,
                         input int pct, input logic [7:0] pat, input int plen, input bit poke_start);
        logic [31:0] dif;
        longint      count;
        longint      k;
        bit          r;
        dif   = fin - ini;
        count = longint'(dif) + 1;
        @(negedge clk);
        chk_flags("pre_idle", 1'b0, 1'b0, 1'b0);
        entrada = hdr; nonce_ini = ini; nonce_fin = fin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble the inputs: the latched values must not follow them.
        entrada = {$urandom, $urandom, $urandom};
        nonce_ini = $urandom; nonce_fin = $urandom;
        k = 0;
        for (int c = 0; c < 4000 && k < count; c++) begin
            chk_flags("run", 1'b1, 1'b1, 1'b0);
            chk("bloque", bloque_in, {hdr, ini + 32'(k)});
            r = (plen > 0) ? pat[c % plen] : (int'($urandom_range(0, 99)) < pct);
            ready_in = r;
            start = poke_start && ($urandom_range(0, 3) == 0);
            if (r) k++;
            @(negedge clk);
        end
        chk("sweep_count", 128'(k), 128'(count));
        start = poke_start;
        ready_in = $urandom_range(0, 1);
        chk_flags("done_cyc", 1'b0, 1'b0, 1'b1);
        chk("bloque_last", bloque_in, {hdr, fin});
        @(negedge clk);
        start = 1'b0;
        chk_flags("post_idle", 1'b0, 1'b0, 1'b0);
        chk("bloque_hold", bloque_in, {hdr, fin});
        @(negedge clk);
        chk_flags("post_idle2", 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [95:0] h;
        logic [31:0] ini;

        // Reset state
        #1;
        chk("rst_bloque", bloque_in, 128'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset_L = 1'b1;
        @(negedge clk);
        chk_flags("idle_no_start", 1'b0, 1'b0, 1'b0);
        chk("idle_bloque_zero", bloque_in, 128'd0);

        // Basic sweep, ready always high
        sweep({24{4'hA}}, 32'd5, 32'd8, 100, 8'h00, 0, 1'b0);
        // Backpressure: ready 1,0,0,1,0,1
        sweep({$urandom, $urandom, $urandom}, 32'd0, 32'd2, 0, 8'b0010_1001, 6, 1'b0);
        // Wrap-around
        sweep({$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 32'h1, 100, 8'h00, 0, 1'b0);
        // Single block, spurious starts during RUN/DONE
        sweep({$urandom, $urandom, $urandom}, 32'h1234, 32'h1234, 100, 8'h00, 0, 1'b1);

        // Async reset mid-sweep
        h = {$urandom, $urandom, $urandom};
        @(negedge clk);
        entrada = h; nonce_ini = 32'd0; nonce_fin = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ready_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_reset_bloque", bloque_in, {h, 32'd10});
        #2 reset_L = 1'b0;
        #1;
        chk("async_rst_bloque", bloque_in, 128'd0);
        chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk_flags("rst_hold", 1'b0, 1'b0, 1'b0);
        reset_L = 1'b1;
        @(negedge clk);
        chk_flags("rst_release", 1'b0, 1'b0, 1'b0);
        sweep({$urandom, $urandom, $urandom}, 32'd20, 32'd23, 100, 8'h00, 0, 1'b0);

        // Randomized sweeps, some crossing the wrap point
        for (int i = 0; i < 8; i++) begin
            ini = (i % 2 == 0) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));
            sweep({$urandom, $urandom, $urandom}, ini, ini + 32'($urandom_range(0, 20)),
                  60, 8'h00, 0, 1'b1);
        end

`ifdef CONCAT_STOP_EN
        // stop coinciding with the handshake of nonce 3
        h = {$urandom, $urandom, $urandom};
        @(negedge clk);
        entrada = h; nonce_ini = 32'd0; nonce_fin = 32'd50; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ready_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("stop_pre_bloque", bloque_in, {h, 32'd3});
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk_flags("stop_done", 1'b0, 1'b0, 1'b1);
        chk("stop_bloque", bloque_in, {h, 32'd3});
        @(negedge clk);
        chk_flags("stop_idle", 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
